// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard for the decode stage: per-register in-flight write
// counters, data/structural/serialize stall generation and a drain FSM.
module reg_scoreboard #(
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwen,
    input  logic             id_serialize,
    input  logic             ex_ready,
    input  logic             kill_valid,
    input  logic [4:0]       kill_rd,
    input  logic             wb_regwen,
    input  logic [4:0]       wb_rd,
    output logic             stall_id,
    output logic             id_issue,
    output logic [5+CNT_W-1:0] outstanding,
    output logic             drain_active,
    output logic             err_sticky
);

    localparam int OUT_W = 5 + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   MAX_W   = {1'b0, CNT_MAX};

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt      [32];
    logic [CNT_W-1:0]     cnt_next [32];
    logic [OUT_W-1:0]     out_next;
    logic                 err_hit;
    logic [CNT_W:0]       up, dn, val;
    logic                 rs1_busy, rs2_busy, rd_dec, haz, sat, ser;

    // x0 is never written, so cnt[0] stays zero and reads of x0 never stall.
    always_comb begin
        rs1_busy = cnt[id_rs1] != '0;
        rs2_busy = cnt[id_rs2] != '0;
        if (WB_BYPASS != 0 && wb_regwen && wb_rd == id_rs1 && cnt[id_rs1] == CNT_W'(1))
            rs1_busy = 1'b0;
        if (WB_BYPASS != 0 && wb_regwen && wb_rd == id_rs2 && cnt[id_rs2] == CNT_W'(1))
            rs2_busy = 1'b0;
        rd_dec   = (wb_regwen && wb_rd == id_rd) || (kill_valid && kill_rd == id_rd);
        haz      = id_valid && ((id_uses_rs1 && rs1_busy) || (id_uses_rs2 && rs2_busy));
        sat      = id_valid && id_regwen && id_rd != '0 && cnt[id_rd] == CNT_MAX && !rd_dec;
        ser      = id_valid && id_serialize && (state == DRAIN || outstanding != '0);
        stall_id = !rst && (haz || sat || ser);
        id_issue = id_valid && !stall_id && ex_ready && !rst;
    end

    // Underflow and overflow clamp the counter and raise the sticky error.
    always_comb begin
        cnt_next[0] = '0;
        out_next    = '0;
        err_hit     = 1'b0;
        up          = '0;
        dn          = '0;
        val         = '0;
        for (int r = 1; r < 32; r++) begin
            up = {1'b0, cnt[r]} + (CNT_W+1)'(id_issue && id_regwen && id_rd == 5'(r));
            dn = (CNT_W+1)'(wb_regwen && wb_rd == 5'(r))
               + (CNT_W+1)'(kill_valid && kill_rd == 5'(r));
            if (dn > up) begin
                cnt_next[r] = '0;
                err_hit     = 1'b1;
            end else begin
                val = up - dn;
                if (val > MAX_W) begin
                    cnt_next[r] = CNT_MAX;
                    err_hit     = 1'b1;
                end else begin
                    cnt_next[r] = val[CNT_W-1:0];
                end
            end
            out_next = out_next + OUT_W'(cnt_next[r]);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (id_valid && id_serialize && outstanding != '0) state_next = DRAIN;
            DRAIN:   if (outstanding == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
            outstanding <= '0;
            err_sticky  <= 1'b0;
            state       <= IDLE;
        end else begin
            for (int r = 0; r < 32; r++) cnt[r] <= cnt_next[r];
            outstanding <= out_next;
            err_sticky  <= err_sticky | err_hit;
            state       <= state_next;
        end
    end

    assign drain_active = (state == DRAIN);

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Register-hazard controller for the decode stage.
- Tracks in-flight writes to each architectural register, from issue at the ID->EX transfer until writeback or squash.
- Produces the decode stall and issue signals that gate the IF/ID and ID/EX pipeline registers.
- Includes a drain FSM so serializing instructions wait until every outstanding write has retired.

Parameters:
- CNT_W, 2, width of each per-register in-flight write counter. Max in-flight writes per register = 2^CNT_W-1.
- WB_BYPASS, 1. When 1, the regfile is write-through, so a same-cycle writeback that clears a register's last pending write releases the stall that cycle. When 0, the stall is released one cycle later.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode holds a valid instruction
- id_rs1  in  5  source register 1 address
- id_rs2  in  5  source register 2 address
- id_uses_rs1  in  1  instruction reads rs1
- id_uses_rs2  in  1  instruction reads rs2
- id_rd  in  5  destination register
- id_regwen  in  1  instruction writes rd
- id_serialize  in  1  instruction must issue with no outstanding writes
- ex_ready  in  1  ID/EX register can accept
- kill_valid  in  1  instruction in EX/MEM squashed before writeback
- kill_rd  in  5  rd of the squashed instruction (only ones that had regwen)
- wb_regwen  in  1  writeback this cycle
- wb_rd  in  5  writeback destination
- stall_id  out  1  hold IF/ID and decode
- id_issue  out  1  instruction transfers to ID/EX this cycle
- outstanding  out  5+CNT_W  total in-flight writes, registered
- drain_active  out  1  FSM in DRAIN
- err_sticky  out  1  sticky counter underflow or overflow

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - All counters = 0, outstanding = 0, FSM = IDLE, err_sticky = 0.
  - stall_id and id_issue are 0 during the reset cycle.
- x0 is never tracked: a counter for x0 does not exist or is read as 0. Issue, kill or wb to rd=0 changes nothing.
- Effective count, eff(r):
  - eff(r) = cnt[r] - 1 if WB_BYPASS=1 and wb_regwen and wb_rd==r and cnt[r]!=0.
  - Otherwise eff(r) = cnt[r].
- Data hazard: haz = id_valid & ((id_uses_rs1 & eff(id_rs1)!=0) | (id_uses_rs2 & eff(id_rs2)!=0)).
- Structural hazard: sat = id_valid & id_regwen & id_rd!=0 & cnt[id_rd]==max & no same-cycle decrement of id_rd.
- Serialize hazard: ser = id_valid & id_serialize & (FSM==DRAIN | outstanding!=0).
- stall_id = haz | sat | ser. Purely combinational from registered state and current inputs; it does not depend on ex_ready.
- id_issue = id_valid & ~stall_id & ex_ready & ~rst.
- Counter update per register r, each cycle:
  - inc = id_issue & id_regwen & id_rd==r
  - dec = (wb_regwen & wb_rd==r) + (kill_valid & kill_rd==r). Up to 2 decrements per cycle.
  - next = cnt + inc - dec.
  - If next would go negative: clamp to 0 and set err_sticky.
  - If next exceeds max: unreachable given sat, but clamp and set err_sticky.
  - A simultaneous inc and dec to the same register leaves the count unchanged.
- outstanding updates the same way as the counter sum, and always equals the sum of all counters after the clamp rules.
- FSM:
  - IDLE -> DRAIN when id_valid & id_serialize & outstanding!=0.
  - DRAIN -> IDLE when outstanding==0 (registered value).
  - In the cycle the FSM returns to IDLE, ser is evaluated on the new state, so the serializing instruction issues one cycle after outstanding reaches 0.
  - If id_valid drops while in DRAIN (front-end flush), the FSM still waits for outstanding==0 before returning to IDLE.
  - Reset mid-drain returns the FSM to IDLE and clears all counters.
- Latency:
  - Counter and FSM updates are visible one cycle after the event.
  - Writeback release is same-cycle when WB_BYPASS=1, otherwise next cycle.

Test Plan:
- Back-to-back dependency: issue add x5 (cnt[5]=1), next instruction reads x5. Expect stall_id=1 until the cycle wb_rd=5; with WB_BYPASS=1, stall_id=0 and id_issue=1 in that same cycle.
- Saturation: with CNT_W=2, issue three writes to x7 with no writeback. The 4th write to x7 gets stall_id=1. One wb_rd=7 in the same cycle lets it issue; cnt[7] stays 3.
- Kill plus writeback same cycle: cnt[3]=2, kill_rd=3 and wb_rd=3 together. Next cycle cnt[3]=0, outstanding decreases by 2, err_sticky=0. An extra wb_rd=3 afterwards sets err_sticky=1 and cnt[3] stays 0.
- Serialize: outstanding=2 and a fence arrives. Expect drain_active=1 and stall_id=1. After both writebacks, outstanding=0, the FSM returns to IDLE, and id_issue=1 on the following cycle.
- x0 and backpressure: an instruction with rd=0 and rs1=0 never stalls and outstanding stays unchanged. With ex_ready=0 and no hazard, expect stall_id=0, id_issue=0, no counter change.
- Reset mid-drain: in DRAIN with cnt[9]=1, assert rst for one cycle. Next cycle drain_active=0, outstanding=0, err_sticky=0, and a reader of x9 issues immediately.
